// File: rtl/pong2p_pixel_gen_if.sv
// rtl/pong2p_pixel_gen_if.sv - pixel position, player controls and display/score outputs of the pong pixel generator
interface pong2p_pixel_gen_if;
  logic        start;
  logic        l_up;
  logic        l_down;
  logic        r_up;
  logic        r_down;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [11:0] rgb;
  logic [3:0]  score_l;
  logic [3:0]  score_r;
  logic        game_over;
  logic        winner;

  modport master (
    output start, l_up, l_down, r_up, r_down, video_on, x, y,
    input  rgb, score_l, score_r, game_over, winner
  );

  modport slave (
    input  start, l_up, l_down, r_up, r_down, video_on, x, y,
    output rgb, score_l, score_r, game_over, winner
  );
endinterface

// File: rtl/pong2p_pixel_gen.sv
// rtl/pong2p_pixel_gen.sv - two-player pong game state and pixel colour generator (PONG_SPEEDUP_EN: ball speeds up on paddle hits)
module pong2p_pixel_gen #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int PAD_HEIGHT   = 72,
  parameter int PAD_WIDTH    = 4,
  parameter int PAD_VELOCITY = 6,
  parameter int L_PAD_X      = 32,
  parameter int R_PAD_X      = 600,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int SCORE_MAX    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input logic               clk,
  input logic               reset,
  pong2p_pixel_gen_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SERVE     = 3'd1;
  localparam logic [2:0] PLAY      = 3'd2;
  localparam logic [2:0] POINT     = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0] BX0        = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] BY0        = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0] PAD_Y0     = 10'((V_ACTIVE - PAD_HEIGHT) / 2);
  localparam logic [9:0] BALL_M1    = 10'(BALL_SIZE - 1);
  localparam logic [9:0] PAD_H_M1   = 10'(PAD_HEIGHT - 1);
  localparam logic [9:0] PAD_VEL    = 10'(PAD_VELOCITY);
  localparam logic [9:0] PAD_DN_LIM = 10'(V_ACTIVE - 1 - PAD_VELOCITY);
  localparam logic [9:0] LX_LO      = 10'(L_PAD_X);
  localparam logic [9:0] LX_HI      = 10'(L_PAD_X + PAD_WIDTH - 1);
  localparam logic [9:0] RX_LO      = 10'(R_PAD_X);
  localparam logic [9:0] RX_HI      = 10'(R_PAD_X + PAD_WIDTH - 1);
  localparam logic [9:0] X_MAX      = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_MAX      = 10'(V_ACTIVE - 1);
  localparam logic [9:0] NET_LO     = 10'(H_ACTIVE / 2 - 1);
  localparam logic [9:0] NET_HI     = 10'(H_ACTIVE / 2);
  localparam logic [9:0] TICK_Y     = 10'(V_ACTIVE + 1);
  localparam logic [3:0] SPD_P      = 4'(BALL_SPEED);
  localparam logic [3:0] SPD_N      = 4'(-BALL_SPEED);
  localparam logic [3:0] SCORE_WIN  = 4'(SCORE_MAX);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

  logic [2:0]       state;
  logic [9:0]       l_top, r_top, bx, by;
  logic [3:0]       dx, dy;
  logic [CNT_W-1:0] serve_cnt;
  logic [3:0]       score_l_q, score_r_q;
  logic             game_over_q, winner_q;
  logic             lost_left;

  logic       tick;
  logic       dx_neg, dx_pos, dy_neg, dy_pos;
  logic [3:0] dx_mag, dy_mag, hit_mag, dx_play, dy_play;
  logic [9:0] dx_mag10, dy_mag10, bx_r, by_b;
  logic       l_ovl, r_ovl, hit_l, hit_r, miss_l, miss_r, refl_t, refl_b;
  logic       on_lpad, on_rpad, on_ball, on_net;
  logic [11:0] rgb_c;

  assign tick     = (bus.y == TICK_Y) && (bus.x == 10'd0);
  assign dx_neg   = dx[3];
  assign dx_pos   = ~dx[3] && (dx != 4'd0);
  assign dy_neg   = dy[3];
  assign dy_pos   = ~dy[3] && (dy != 4'd0);
  assign dx_mag   = dx_neg ? (4'd0 - dx) : dx;
  assign dy_mag   = dy_neg ? (4'd0 - dy) : dy;
  assign dx_mag10 = {6'd0, dx_mag};
  assign dy_mag10 = {6'd0, dy_mag};
  assign bx_r     = bx + BALL_M1;
  assign by_b     = by + BALL_M1;

  // Edge tests all use the position before this frame's move, so the ball turns one step early.
  assign l_ovl  = (by <= l_top + PAD_H_M1) && (by_b >= l_top);
  assign r_ovl  = (by <= r_top + PAD_H_M1) && (by_b >= r_top);
  assign hit_l  = dx_neg && (bx >= LX_LO) && (bx <= LX_HI + dx_mag10) && l_ovl;
  assign hit_r  = dx_pos && (bx_r >= RX_LO - dx_mag10) && (bx_r <= RX_HI) && r_ovl;
  assign miss_l = dx_neg && (bx <= dx_mag10);
  assign miss_r = dx_pos && (bx_r >= X_MAX - dx_mag10);
  assign refl_t = dy_neg && (by <= dy_mag10);
  assign refl_b = dy_pos && (by_b >= Y_MAX - dy_mag10);

`ifdef PONG_SPEEDUP_EN
  assign hit_mag = (dx_mag >= 4'd7) ? 4'd7 : (dx_mag + 4'd1);
`else
  assign hit_mag = dx_mag;
`endif

  assign dx_play = hit_l ? hit_mag : (hit_r ? (4'd0 - hit_mag) : dx);
  assign dy_play = refl_t ? dy_mag : (refl_b ? (4'd0 - dy_mag) : dy);

  function automatic logic [9:0] pad_next(input logic [9:0] top, input logic up, input logic down);
    logic [9:0] nxt;
    nxt = top;
    if (up) begin
      if (top > PAD_VEL) nxt = top - PAD_VEL;
    end else if (down) begin
      if (top + PAD_H_M1 < PAD_DN_LIM) nxt = top + PAD_VEL;
    end
    return nxt;
  endfunction

  // Game state: paddles, ball, scores and the serve/play/point/game-over sequence, advanced once per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      l_top       <= PAD_Y0;
      r_top       <= PAD_Y0;
      bx          <= BX0;
      by          <= BY0;
      dx          <= SPD_P;
      dy          <= SPD_P;
      serve_cnt   <= '0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      lost_left   <= 1'b0;
    end else if (tick) begin
      if (state == SERVE || state == PLAY) begin
        l_top <= pad_next(l_top, bus.l_up, bus.l_down);
        r_top <= pad_next(r_top, bus.r_up, bus.r_down);
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            serve_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (serve_cnt == SERVE_LAST) begin
            serve_cnt <= '0;
            state     <= PLAY;
          end else begin
            serve_cnt <= serve_cnt + 1'b1;
          end
        end
        PLAY: begin
          dy <= dy_play;
          if (hit_l || hit_r) begin
            dx <= dx_play;
            bx <= bx + {{6{dx_play[3]}}, dx_play};
            by <= by + {{6{dy_play[3]}}, dy_play};
          end else if (miss_l) begin
            score_r_q <= score_r_q + 4'd1;
            lost_left <= 1'b1;
            state     <= POINT;
          end else if (miss_r) begin
            score_l_q <= score_l_q + 4'd1;
            lost_left <= 1'b0;
            state     <= POINT;
          end else begin
            bx <= bx + {{6{dx_play[3]}}, dx_play};
            by <= by + {{6{dy_play[3]}}, dy_play};
          end
        end
        POINT: begin
          if (score_l_q == SCORE_WIN) begin
            game_over_q <= 1'b1;
            winner_q    <= 1'b0;
            state       <= GAME_OVER;
          end else if (score_r_q == SCORE_WIN) begin
            game_over_q <= 1'b1;
            winner_q    <= 1'b1;
            state       <= GAME_OVER;
          end else begin
            bx        <= BX0;
            by        <= BY0;
            dx        <= lost_left ? SPD_N : SPD_P;
            dy        <= SPD_P;
            serve_cnt <= '0;
            state     <= SERVE;
          end
        end
        GAME_OVER: begin
          if (bus.start) begin
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            game_over_q <= 1'b0;
            bx          <= BX0;
            by          <= BY0;
            dx          <= SPD_P;
            dy          <= SPD_P;
            serve_cnt   <= '0;
            state       <= SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign on_lpad = (bus.x >= LX_LO) && (bus.x <= LX_HI) && (bus.y >= l_top) && (bus.y <= l_top + PAD_H_M1);
  assign on_rpad = (bus.x >= RX_LO) && (bus.x <= RX_HI) && (bus.y >= r_top) && (bus.y <= r_top + PAD_H_M1);
  assign on_ball = (state != GAME_OVER) && (bus.x >= bx) && (bus.x <= bx_r) && (bus.y >= by) && (bus.y <= by_b);
  assign on_net  = (bus.x >= NET_LO) && (bus.x <= NET_HI) && !bus.y[4];

  // Pixel colour by layer priority, combinational so it lines up with the incoming x/y.
  always_comb begin
    rgb_c = 12'h111;
    if (!bus.video_on)  rgb_c = 12'h000;
    else if (on_lpad)   rgb_c = 12'h0F0;
    else if (on_rpad)   rgb_c = 12'h00F;
    else if (on_ball)   rgb_c = 12'hF00;
    else if (on_net)    rgb_c = 12'h888;
  end

  assign bus.rgb       = rgb_c;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule
